// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_ctrl clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, STOP} state_t;

  localparam logic [31:0] DIV_MIN = 32'd2;

  function automatic logic is_legal_div(input logic [31:0] value);
    return value >= DIV_MIN;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Divisor-change request handshake between a requester and clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             div_req_valid;
  logic [DIV_W-1:0] div_req_value;
  logic             div_req_ready;

  modport master (output div_req_valid, div_req_value, input div_req_ready);
  modport slave  (input div_req_valid, div_req_value, output div_req_ready);
endinterface

// File: rtl/clk_div_core.sv
// Divide counter, registered waveform and clock-enable strobe; all outputs are
// computed from next-cycle values so they line up with the counter register.
module clk_div_core #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] load_value,
  output logic [DIV_W-1:0] div_active,
  output logic             wrap,
  output logic             high_pos,
  output logic             clk_en_pulse
);

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic             run_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic             high_nxt;
  logic             en_nxt;

  // D >= 2 always holds, so D-1 never underflows and cnt never exceeds D-1.
  assign wrap = (cnt == div_active - ONE);

  always_comb begin
    div_nxt  = load ? load_value : div_active;
    cnt_nxt  = '0;
    // The first running cycle after idle starts at zero rather than incrementing.
    if (run && run_q) cnt_nxt = wrap ? '0 : cnt + ONE;
    high_nxt = run && (cnt_nxt < (div_nxt >> 1));
    en_nxt   = run && (cnt_nxt == div_nxt - ONE);
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      cnt          <= '0;
      div_active   <= DIV_RST_V;
      high_pos     <= 1'b0;
      clk_en_pulse <= 1'b0;
    end else begin
      run_q        <= run;
      cnt          <= cnt_nxt;
      div_active   <= div_nxt;
      high_pos     <= high_nxt;
      clk_en_pulse <= en_nxt;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider controller: FSM and divisor handshake.
// Optional macro CLK_DIV_ODD_DUTY_EN adds a negedge retime for 50% duty on odd D.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic               clkin,
  input  logic               reset_n,
  input  logic               enable,
  clk_div_ctrl_if.slave      req,
  output logic [DIV_W-1:0]   div_active,
  output logic               busy,
  output logic               clkout,
  output logic               clk_en_pulse,
  output logic               err_pulse
);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] pending;
  logic [DIV_W-1:0] load_value;
  logic             load;
  logic             run;
  logic             wrap;
  logic             high_pos;
  logic             xfer;
  logic             legal;

  assign req.div_req_ready = (state == IDLE) || (state == RUN);
  assign xfer              = req.div_req_valid && req.div_req_ready;
  assign legal             = is_legal_div(32'(req.div_req_value));
  assign busy              = (state != IDLE);
  assign run               = (state_nxt != IDLE);

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_value = req.div_req_value;
    case (state)
      IDLE: begin
        if (xfer && legal) load = 1'b1;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (xfer && legal) state_nxt = DRAIN;
        else if (!enable)  state_nxt = STOP;
      end
      DRAIN: begin
        // Swap divisors only on the period boundary so clkout never glitches.
        if (wrap) begin
          load       = 1'b1;
          load_value = pending;
          state_nxt  = enable ? RUN : IDLE;
        end
      end
      STOP: begin
        if (enable)    state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pending   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_pulse <= xfer && !legal;
      if (state == RUN && xfer && legal) pending <= req.div_req_value;
    end
  end

  clk_div_core #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_core (
    .clkin        (clkin),
    .reset_n      (reset_n),
    .run          (run),
    .load         (load),
    .load_value   (load_value),
    .div_active   (div_active),
    .wrap         (wrap),
    .high_pos     (high_pos),
    .clk_en_pulse (clk_en_pulse)
  );

`ifdef CLK_DIV_ODD_DUTY_EN
  logic high_neg;

  // Half-cycle delayed copy of the high term stretches odd-D high time by 0.5.
  always_ff @(negedge clkin or negedge reset_n) begin
    if (!reset_n) high_neg <= 1'b0;
    else          high_neg <= high_pos;
  end

  assign clkout = high_pos | (div_active[0] & high_neg);
`else
  assign clkout = high_pos;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset, waveform, divisor changes, stop, errors.
module tb_clk_div_ctrl;

  logic       clkin = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] div_active;
  logic       busy;
  logic       clkout;
  logic       clk_en_pulse;
  logic       err_pulse;
  int         n_tests = 0;
  int         n_fail  = 0;

  clk_div_ctrl_if #(.DIV_W(8)) req_if ();

  clk_div_ctrl #(.DIV_W(8), .DIV_RESET(3)) dut (
    .clkin        (clkin),
    .reset_n      (reset_n),
    .enable       (enable),
    .req          (req_if),
    .div_active   (div_active),
    .busy         (busy),
    .clkout       (clkout),
    .clk_en_pulse (clk_en_pulse),
    .err_pulse    (err_pulse)
  );

  always #5 clkin = ~clkin;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic sync_period();
    int k = 0;
    do begin step(); k++; end while (clk_en_pulse !== 1'b1 && k < 600);
    n_tests++;
    if (clk_en_pulse !== 1'b1) begin n_fail++; $display("FAIL sync_timeout: clk_en_pulse=%b after %0d cycles, required 1", clk_en_pulse, k); end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 600) begin step(); k++; end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, k); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    req_if.div_req_valid = 1'b0; req_if.div_req_value = '0;
    #12;
    n_tests++; if (clkout !== 1'b0) begin n_fail++; $display("FAIL reset_clkout: got %b want 0", clkout); end
    n_tests++; if (clk_en_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", clk_en_pulse); end
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_pulse); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (div_active !== 8'd3) begin n_fail++; $display("FAIL reset_div: got %0d want 3", div_active); end
    n_tests++; if (req_if.div_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_if.div_req_ready); end
    step(); #3; reset_n = 1'b1;
    step();
    n_tests++; if (busy !== 1'b0 || clkout !== 1'b0) begin n_fail++; $display("FAIL idle_hold: busy=%b clkout=%b want 0 0", busy, clkout); end
  endtask

  task automatic test_run_d3();
    enable = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      n_tests++; if (clkout !== (i % 3 == 0)) begin n_fail++; $display("FAIL d3_clkout[%0d]: got %b want %b", i, clkout, (i % 3 == 0)); end
      n_tests++; if (clk_en_pulse !== (i % 3 == 2)) begin n_fail++; $display("FAIL d3_en[%0d]: got %b want %b", i, clk_en_pulse, (i % 3 == 2)); end
      n_tests++; if (div_active !== 8'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL d3_status[%0d]: div=%0d busy=%b want 3 1", i, div_active, busy); end
      step();
    end
  endtask

  task automatic test_illegal();
    logic exp_clk [3] = '{1'b1, 1'b0, 1'b0};
    logic exp_en  [3] = '{1'b0, 1'b0, 1'b1};
    logic exp_err [3] = '{1'b1, 1'b0, 1'b0};
    sync_period();
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd1;
    step();
    req_if.div_req_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_tests++; if (err_pulse !== exp_err[j]) begin n_fail++; $display("FAIL illegal_err[%0d]: got %b want %b", j, err_pulse, exp_err[j]); end
      n_tests++; if (clkout !== exp_clk[j] || clk_en_pulse !== exp_en[j]) begin n_fail++; $display("FAIL illegal_wave[%0d]: clkout=%b en=%b want %b %b", j, clkout, clk_en_pulse, exp_clk[j], exp_en[j]); end
      n_tests++; if (div_active !== 8'd3 || req_if.div_req_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_div[%0d]: div=%0d ready=%b want 3 1", j, div_active, req_if.div_req_ready); end
      step();
    end
  endtask

  task automatic test_div_change();
    logic exp_clk [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_en  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_rdy [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int   exp_div [8] = '{3, 3, 5, 5, 5, 5, 5, 5};
    sync_period();
    step();
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd5;
    n_tests++; if (req_if.div_req_ready !== 1'b1) begin n_fail++; $display("FAIL chg_ready_before: got %b want 1", req_if.div_req_ready); end
    step();
    req_if.div_req_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      n_tests++; if (clkout !== exp_clk[j]) begin n_fail++; $display("FAIL chg_clkout[%0d]: got %b want %b", j, clkout, exp_clk[j]); end
      n_tests++; if (clk_en_pulse !== exp_en[j]) begin n_fail++; $display("FAIL chg_en[%0d]: got %b want %b", j, clk_en_pulse, exp_en[j]); end
      n_tests++; if (req_if.div_req_ready !== exp_rdy[j]) begin n_fail++; $display("FAIL chg_ready[%0d]: got %b want %b", j, req_if.div_req_ready, exp_rdy[j]); end
      n_tests++; if (32'(div_active) !== exp_div[j]) begin n_fail++; $display("FAIL chg_div[%0d]: got %0d want %0d", j, div_active, exp_div[j]); end
      step();
    end
  endtask

  task automatic test_stop();
    sync_period();
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd4;
    step();
    req_if.div_req_valid = 1'b0;
    sync_period();
    step();
    n_tests++; if (div_active !== 8'd4 || clkout !== 1'b1) begin n_fail++; $display("FAIL stop_d4_start: div=%0d clkout=%b want 4 1", div_active, clkout); end
    step();
    n_tests++; if (clkout !== 1'b1) begin n_fail++; $display("FAIL stop_cnt1: clkout=%b want 1", clkout); end
    enable = 1'b0;
    step();
    n_tests++; if (clkout !== 1'b0 || busy !== 1'b1 || clk_en_pulse !== 1'b0 || req_if.div_req_ready !== 1'b0) begin n_fail++; $display("FAIL stop_cnt2: clkout=%b busy=%b en=%b ready=%b want 0 1 0 0", clkout, busy, clk_en_pulse, req_if.div_req_ready); end
    step();
    n_tests++; if (clkout !== 1'b0 || busy !== 1'b1 || clk_en_pulse !== 1'b1) begin n_fail++; $display("FAIL stop_cnt3: clkout=%b busy=%b en=%b want 0 1 1", clkout, busy, clk_en_pulse); end
    step();
    n_tests++; if (clkout !== 1'b0 || busy !== 1'b0 || clk_en_pulse !== 1'b0 || req_if.div_req_ready !== 1'b1) begin n_fail++; $display("FAIL stop_idle: clkout=%b busy=%b en=%b ready=%b want 0 0 0 1", clkout, busy, clk_en_pulse, req_if.div_req_ready); end
    step();
    n_tests++; if (clkout !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle_hold: clkout=%b busy=%b want 0 0", clkout, busy); end
    enable = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      n_tests++; if (clkout !== (j < 2) || busy !== 1'b1) begin n_fail++; $display("FAIL restart[%0d]: clkout=%b busy=%b want %b 1", j, clkout, busy, (j < 2)); end
    end
  endtask

  task automatic test_reset_drain();
    sync_period();
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd7;
    step();
    req_if.div_req_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || req_if.div_req_ready !== 1'b0 || clkout !== 1'b1) begin n_fail++; $display("FAIL drain_entry: busy=%b ready=%b clkout=%b want 1 0 1", busy, req_if.div_req_ready, clkout); end
    #3; reset_n = 1'b0; #1;
    n_tests++; if (clkout !== 1'b0 || clk_en_pulse !== 1'b0 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs: clkout=%b en=%b err=%b want 0 0 0", clkout, clk_en_pulse, err_pulse); end
    n_tests++; if (busy !== 1'b0 || div_active !== 8'd3 || req_if.div_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state: busy=%b div=%0d ready=%b want 0 3 1", busy, div_active, req_if.div_req_ready); end
    step(); step(); #3; reset_n = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      n_tests++; if (clkout !== (i % 3 == 0) || div_active !== 8'd3 || req_if.div_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_resume[%0d]: clkout=%b div=%0d ready=%b want %b 3 1", i, clkout, div_active, req_if.div_req_ready, (i % 3 == 0)); end
      step();
    end
  endtask

  task automatic test_idle_ops();
    enable = 1'b0;
    wait_idle();
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd2;
    step();
    req_if.div_req_valid = 1'b0;
    n_tests++; if (div_active !== 8'd2 || busy !== 1'b0 || clkout !== 1'b0) begin n_fail++; $display("FAIL idle_load: div=%0d busy=%b clkout=%b want 2 0 0", div_active, busy, clkout); end
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd0;
    step();
    req_if.div_req_valid = 1'b0;
    n_tests++; if (err_pulse !== 1'b1 || div_active !== 8'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_zero: err=%b div=%0d busy=%b want 1 2 0", err_pulse, div_active, busy); end
    step();
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL idle_err_clear: got %b want 0", err_pulse); end
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd6; enable = 1'b1;
    step();
    req_if.div_req_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      n_tests++; if (clkout !== (j < 3) || clk_en_pulse !== (j == 5) || div_active !== 8'd6) begin n_fail++; $display("FAIL idle_start6[%0d]: clkout=%b en=%b div=%0d want %b %b 6", j, clkout, clk_en_pulse, div_active, (j < 3), (j == 5)); end
      step();
    end
  endtask

  task automatic test_max_div();
    int highs = 0;
    int ens   = 0;
    int enpos = -1;
    enable = 1'b0;
    wait_idle();
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd255; enable = 1'b1;
    step();
    req_if.div_req_valid = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (clkout === 1'b1) highs++;
      if (clk_en_pulse === 1'b1) begin ens++; enpos = i; end
      step();
    end
    n_tests++; if (highs !== 127) begin n_fail++; $display("FAIL max_high: got %0d want 127", highs); end
    n_tests++; if (ens !== 1 || enpos !== 254) begin n_fail++; $display("FAIL max_en: count=%0d pos=%0d want 1 254", ens, enpos); end
    n_tests++; if (clkout !== 1'b1 || clk_en_pulse !== 1'b0 || div_active !== 8'd255) begin n_fail++; $display("FAIL max_wrap: clkout=%b en=%b div=%0d want 1 0 255", clkout, clk_en_pulse, div_active); end
  endtask

  task automatic test_duty();
    int highs = 0;
    int exp_highs;
`ifdef CLK_DIV_ODD_DUTY_EN
    exp_highs = 3;
`else
    exp_highs = 2;
`endif
    enable = 1'b0;
    wait_idle();
    req_if.div_req_valid = 1'b1; req_if.div_req_value = 8'd3; enable = 1'b1;
    step();
    req_if.div_req_valid = 1'b0;
    for (int h = 0; h < 6; h++) begin
      if (clkout === 1'b1) highs++;
      if (h % 2 == 0) begin @(negedge clkin); #1; end
      else step();
    end
    n_tests++; if (highs !== exp_highs) begin n_fail++; $display("FAIL duty_d3: high half-cycles=%0d want %0d", highs, exp_highs); end
  endtask

  initial begin
    test_reset();
    test_run_d3();
    test_illegal();
    test_div_change();
    test_stop();
    test_reset_drain();
    test_idle_ops();
    test_max_div();
    test_duty();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
